// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
// Shares one single-port, byte-addressed instruction memory between the fetch
// stage (word reads) and the program loader (word writes). Fetch is held off
// until loading completes. After that the loader may still write, and a burst
// guard makes sure a pending fetch is served after at most MAX_BURST loader
// grants in a row. Requests that are misaligned or out of range are consumed
// with an addr_err pulse and never reach the memory.
module imem_access_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_BYTES = 188,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic              boot_done,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);
    // MEM_LAT is limited to 1..4, so a 3-bit latency counter always suffices.
    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_RD_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_nxt;
    logic [2:0]         r_lat_cnt;
    logic [2:0]         w_lat_nxt;
    logic               r_flush_seen;
    logic               w_flush_nxt;
    logic               r_boot_done;

    logic               w_grant_if;
    logic               w_grant_ld;
    logic               w_rsp_fire;
    logic               w_if_ok;
    logic               w_ld_ok;
    logic               w_at_cap;
    logic               w_lat_last;

    // A word access is legal when word-aligned and its last byte lies inside
    // the array; the sum is formed in 33 bits so high addresses cannot wrap.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [32:0] last_byte;
        last_byte = {1'b0, a} + 33'd3;
        return (a[1:0] == 2'b00) && (last_byte < 33'(MEM_BYTES));
    endfunction

    assign w_if_ok    = addr_ok(if_addr);
    assign w_ld_ok    = addr_ok(ld_addr);
    assign w_at_cap   = (r_burst_cnt == BURST_CAP);
    assign w_lat_last = (r_lat_cnt == LAT_LAST);
    assign boot_done  = r_boot_done;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) is reserved for combinational blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst guard, read latency tracking, flush capture and the sticky boot flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst_cnt  <= '0;
            r_lat_cnt    <= '0;
            r_flush_seen <= 1'b0;
            r_boot_done  <= 1'b0;
        end else begin
            r_burst_cnt  <= w_burst_nxt;
            r_lat_cnt    <= w_lat_nxt;
            r_flush_seen <= w_flush_nxt;
            if (r_state == ST_BOOT && ld_done) begin
                r_boot_done <= 1'b1;
            end
        end
    end

    // Arbitration, next-state selection and memory/handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_burst_nxt  = r_burst_cnt;
        w_lat_nxt    = r_lat_cnt;
        w_flush_nxt  = r_flush_seen;
        w_grant_if   = 1'b0;
        w_grant_ld   = 1'b0;
        w_rsp_fire   = 1'b0;
        if_req_ready = 1'b0;
        ld_req_ready = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        addr_err     = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (r_state)
            ST_BOOT: begin
                // Only the loader is served; a write in the ld_done cycle still lands.
                w_grant_ld = ld_req_valid;
                if (ld_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // The loader wins a contested cycle until it has taken MAX_BURST
                // grants in a row; the pending fetch then goes next.
                if (if_req_valid && (!ld_req_valid || w_at_cap)) begin
                    w_grant_if = 1'b1;
                end else if (ld_req_valid) begin
                    w_grant_ld = 1'b1;
                end

                // A rejected request leaves the burst count untouched.
                if (w_grant_if) begin
                    if (w_if_ok) begin
                        w_burst_nxt = '0;
                        w_lat_nxt   = '0;
                        w_flush_nxt = 1'b0;
                        w_state_nxt = ST_RD_WAIT;
                    end
                end else if (w_grant_ld) begin
                    if (w_ld_ok) begin
                        w_burst_nxt = w_at_cap ? r_burst_cnt : r_burst_cnt + BURST_W'(1);
                    end
                end else begin
                    w_burst_nxt = '0;
                end
            end
            ST_RD_WAIT: begin
                // A flush anywhere in the wait, including the final cycle, drops
                // the response but does not change when RUN is re-entered.
                if (w_lat_last) begin
                    w_rsp_fire  = !(r_flush_seen || if_flush);
                    w_lat_nxt   = '0;
                    w_flush_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_lat_nxt   = r_lat_cnt + 3'd1;
                    w_flush_nxt = r_flush_seen || if_flush;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        if_req_ready = w_grant_if;
        ld_req_ready = w_grant_ld;

        if (w_grant_if) begin
            if (w_if_ok) begin
                mem_en   = 1'b1;
                mem_addr = if_addr[ADDR_W-1:0];
            end else begin
                addr_err = 1'b1;
            end
        end

        if (w_grant_ld) begin
            if (w_ld_ok) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ld_addr[ADDR_W-1:0];
                mem_wdata = ld_data;
            end else begin
                addr_err = 1'b1;
            end
        end

        if_rsp_valid = w_rsp_fire;
        if (w_rsp_fire) begin
            if_rsp_data = mem_rdata;
        end

        // While reset is held every output is forced low, including the
        // handshake readies that BOOT would otherwise raise.
        if (!rst) begin
            if_req_ready = 1'b0;
            ld_req_ready = 1'b0;
            if_rsp_valid = 1'b0;
            if_rsp_data  = '0;
            addr_err     = 1'b0;
            mem_en       = 1'b0;
            mem_we       = 1'b0;
            mem_addr     = '0;
            mem_wdata    = '0;
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter
// Directed bench for imem_access_arbiter with default parameters. A small
// byte-array memory with one cycle of read latency stands in for the array.
// Inputs change one time unit after each rising edge; outputs are sampled one
// time unit later, well before the next edge.
module tb_imem_access_arbiter;

    localparam int MEM_BYTES = 188;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        boot_done;
    logic        addr_err;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    imem_access_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_done      (ld_done),
        .boot_done    (boot_done),
        .addr_err     (addr_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: big-endian word writes, read data one cycle after the strobe.
    logic [7:0] mem_b [0:MEM_BYTES-1];

    function automatic logic [7:0] rd_byte(input int a);
        return (a < MEM_BYTES) ? mem_b[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(mem_addr) + k < MEM_BYTES) begin
                    mem_b[int'(mem_addr) + k] <= mem_wdata[31 - 8*k -: 8];
                end
            end
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= {rd_byte(int'(mem_addr)), rd_byte(int'(mem_addr) + 1),
                          rd_byte(int'(mem_addr) + 2), rd_byte(int'(mem_addr) + 3)};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_valid = 1'b0;
        if_addr      = '0;
        if_flush     = 1'b0;
        ld_req_valid = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        ld_done      = 1'b0;
    endtask

    typedef struct {
        logic        ifv;
        logic [31:0] ifa;
        logic        ldv;
        logic [31:0] lda;
        logic [31:0] ldd;
        logic        done;
        logic        e_ifr;
        logic        e_ldr;
        logic        e_en;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        logic        e_rsp;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_boot;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_grants;
        logic [7:0] g;

        // ifv ifa ldv lda ldd done | ifr ldr en we addr wdata rsp rdata err boot
        // Boot: three writes, fetch held off; ld_done with the third write.
        vecs[0]  = '{1'b1, 32'h0, 1'b1, 32'h0, 32'hE3A00014, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 32'hE3A00014, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0, 1'b1, 32'h4, 32'h11223344, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 32'h11223344, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h0, 1'b1, 32'h8, 32'hA5A55A5A, 1'b1,
                     1'b0, 1'b1, 1'b1, 1'b1, 8'h08, 32'hA5A55A5A, 1'b0, 32'h0, 1'b0, 1'b0};
        // RUN: fetch 0 accepted, response in the following (RD_WAIT) cycle.
        vecs[3]  = '{1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'hE3A00014, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 8'h04, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'h11223344, 1'b0, 1'b1};
        // Rejected fetches: misaligned, one past the last legal word, wrap-around.
        vecs[7]  = '{1'b1, 32'h2, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 32'hBC, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
        // Post-boot write to the last legal word, then fetch it back.
        vecs[10] = '{1'b0, 32'h0, 1'b1, 32'hB8, 32'hCAFEF00D, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 8'hB8, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'hB8, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 8'hB8, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
        // Rejected loader writes: wrap-around, aliasing 0x100, misaligned.
        vecs[13] = '{1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 32'h12345678, 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 32'h0, 1'b1, 32'h100, 32'h12345678, 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 32'h0, 1'b1, 32'h6, 32'h12345678, 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};

        for (int a = 0; a < MEM_BYTES; a++) mem_b[a] = 8'h00;
        mem_rdata = '0;

        // Reset held with both requesters active: every output stays low.
        rst = 1'b0;
        clear_inputs();
        if_req_valid = 1'b1;
        ld_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ld_ready",  ld_req_ready, 1'b0);
        check("rst_if_ready",  if_req_ready, 1'b0);
        check("rst_mem_en",    mem_en,       1'b0);
        check("rst_boot_done", boot_done,    1'b0);
        check("rst_rsp_valid", if_rsp_valid, 1'b0);
        check("rst_addr_err",  addr_err,     1'b0);

        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if_req_valid = vecs[i].ifv;
            if_addr      = vecs[i].ifa;
            ld_req_valid = vecs[i].ldv;
            ld_addr      = vecs[i].lda;
            ld_data      = vecs[i].ldd;
            ld_done      = vecs[i].done;
            if_flush     = 1'b0;
            #1;
            check($sformatf("v%0d_if_ready", i), if_req_ready, vecs[i].e_ifr);
            check($sformatf("v%0d_ld_ready", i), ld_req_ready, vecs[i].e_ldr);
            check($sformatf("v%0d_mem_en", i),   mem_en,       vecs[i].e_en);
            check($sformatf("v%0d_mem_we", i),   mem_we,       vecs[i].e_we);
            check($sformatf("v%0d_rsp_valid", i), if_rsp_valid, vecs[i].e_rsp);
            check($sformatf("v%0d_addr_err", i), addr_err,     vecs[i].e_err);
            check($sformatf("v%0d_boot_done", i), boot_done,   vecs[i].e_boot);
            if (vecs[i].e_en) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            if (vecs[i].e_we) check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wd);
            if (vecs[i].e_rsp) check($sformatf("v%0d_rsp_data", i), if_rsp_data, vecs[i].e_rd);
            next_cycle();
        end

        // Contention: both requesters valid every cycle -> L,L,L,L,F repeating.
        clear_inputs();
        if_req_valid = 1'b1;
        if_addr      = 32'h0;
        ld_req_valid = 1'b1;
        ld_addr      = 32'h10;
        ld_data      = 32'h0BADF00D;
        n_grants = 0;
        for (int c = 0; c < 30 && n_grants < 10; c++) begin
            #1;
            check("burst_single_grant", {31'd0, if_req_ready && ld_req_ready}, 32'd0);
            if (if_req_ready || ld_req_ready) begin
                g = if_req_ready ? "F" : "L";
                check($sformatf("burst_grant%0d", n_grants), g, (n_grants % 5 == 4) ? "F" : "L");
                n_grants++;
            end
            next_cycle();
        end
        check("burst_grant_count", n_grants, 10);
        clear_inputs();
        #1;
        check("burst_rsp_valid", if_rsp_valid, 1'b1);
        check("burst_rsp_data",  if_rsp_data,  32'hE3A00014);
        next_cycle();

        // Flush during the wait: no response, next fetch taken right after.
        if_req_valid = 1'b1;
        if_addr      = 32'h4;
        #1;
        check("flush_accept", if_req_ready, 1'b1);
        next_cycle();
        if_req_valid = 1'b0;
        if_flush     = 1'b1;
        #1;
        check("flush_rsp_suppressed", if_rsp_valid, 1'b0);
        next_cycle();
        if_flush     = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 32'h8;
        #1;
        check("flush_next_accept", if_req_ready, 1'b1);
        check("flush_next_mem_en", mem_en, 1'b1);
        check("flush_next_addr",   mem_addr, 8'h08);
        next_cycle();
        if_req_valid = 1'b0;
        #1;
        check("flush_next_rsp_valid", if_rsp_valid, 1'b1);
        check("flush_next_rsp_data",  if_rsp_data,  32'hA5A55A5A);
        next_cycle();

        // Reset dropped in the middle of a read.
        if_req_valid = 1'b1;
        if_addr      = 32'h0;
        #1;
        check("mid_rst_accept", if_req_ready, 1'b1);
        next_cycle();
        ld_req_valid = 1'b1;
        ld_addr      = 32'h20;
        rst = 1'b0;
        #1;
        check("mid_rst_rsp_valid", if_rsp_valid, 1'b0);
        check("mid_rst_boot_done", boot_done,    1'b0);
        check("mid_rst_if_ready",  if_req_ready, 1'b0);
        check("mid_rst_ld_ready",  ld_req_ready, 1'b0);
        check("mid_rst_mem_en",    mem_en,       1'b0);
        next_cycle();
        rst = 1'b1;
        ld_req_valid = 1'b0;
        #1;
        check("post_rst_if_blocked", if_req_ready, 1'b0);
        check("post_rst_boot_done",  boot_done,    1'b0);
        check("post_rst_mem_en",     mem_en,       1'b0);
        next_cycle();
        ld_done = 1'b1;
        #1;
        check("reboot_if_blocked", if_req_ready, 1'b0);
        check("reboot_boot_low",   boot_done,    1'b0);
        next_cycle();
        ld_done = 1'b0;
        #1;
        check("reboot_boot_done", boot_done,    1'b1);
        check("reboot_if_accept", if_req_ready, 1'b1);
        next_cycle();
        clear_inputs();
        #1;
        check("reboot_rsp_valid", if_rsp_valid, 1'b1);
        check("reboot_rsp_data",  if_rsp_data,  32'hE3A00014);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
